// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// load/store data path. Data requests win by default; a saturating counter
// forces a fetch grant after STARVE_MAX back-to-back data grants that each
// overtook a pending fetch. Each transaction walks IDLE->ISSUE->WAIT->ACK.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int LAT_W    = $clog2(MEM_LAT + 1);
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT);
   localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK
   } state_t;

   state_t              state_q, state_d;
   logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                win_data_q, win_data_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                if_ack_q, if_ack_d;
   logic                d_ack_q, d_ack_d;
   logic                grant_data;
   logic                ack_pending;

   // State and datapath registers; reset abandons any in-flight access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         win_data_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         win_data_q   <= win_data_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_ack_q     <= if_ack_d;
         d_ack_q      <= d_ack_d;
      end
   end

   // Next-state logic: arbitration and command latch in IDLE, latency count
   // in WAIT, ack generation in ACK. The ack flop becomes visible the cycle
   // after ACK while the requester still holds req, so IDLE must not grant
   // in that cycle or the same request would be served twice.
   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      win_data_d   = win_data_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_ack_d     = 1'b0;
      d_ack_d      = 1'b0;
      grant_data   = 1'b0;
      ack_pending  = if_ack_q | d_ack_q;

      case (state_q)
         S_IDLE: begin
            if ((if_req || d_req) && !ack_pending) begin
               grant_data = d_req && !(if_req && (starve_cnt_q == STARVE_LIM));
               win_data_d = grant_data;
               if (grant_data) begin
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  if (!if_req) begin
                     starve_cnt_d = '0;
                  end else if (starve_cnt_q < STARVE_LIM) begin
                     starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                  end
               end else begin
                  mem_we_d     = 1'b0;
                  mem_addr_d   = if_addr;
                  mem_wdata_d  = '0;
                  starve_cnt_d = '0;
               end
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            lat_cnt_d = LAT_LOAD;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
            if (lat_cnt_q == LAT_LAST) begin
               if (!win_data_q) begin
                  if_rdata_d = mem_rdata;
               end else if (!mem_we_q) begin
                  d_rdata_d = mem_rdata;
               end
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if_ack_d = !win_data_q;
            d_ack_d  = win_data_q;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Stimulus pushes expected memory
// commands and acks into queues; monitors pop and compare when the DUT
// presents mem_en or an ack. A second instance with MEM_LAT=3 covers the
// back-to-back spacing of a continuously held request.
module tb_mem_port_arbiter;

   typedef struct {
      bit          is_data;
      logic [31:0] rdata;
      int          cycle;
   } ack_exp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cycle;
   } cmd_exp_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } rd_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b1, d_req = 1'b1, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic        if_ack, d_ack, mem_en, mem_we, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic        d_req3 = 1'b0;
   logic        if_ack3, d_ack3, mem_en3, mem_we3, busy3;
   logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;

   int          cyc = 0;
   int          tests_run = 0;
   int          tests_failed = 0;
   ack_exp_t    ack_exp_q[$];
   cmd_exp_t    cmd_exp_q[$];
   rd_t         rd_q[$];
   logic [31:0] mem_model [logic [31:0]];
   int          en3_q[$];
   int          ack3_cycle = -1;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk(clk), .reset(reset),
      .if_req(1'b0), .if_addr(32'h0), .if_ack(if_ack3), .if_rdata(if_rdata3),
      .d_req(d_req3), .d_we(1'b0), .d_addr(32'h60), .d_wdata(32'h0),
      .d_ack(d_ack3), .d_rdata(d_rdata3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_rdata(32'h0000_1234), .busy(busy3)
   );

   // Free-running clock and cycle counter.
   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic failNow(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d", name, cyc);
   endtask

   // Memory model: read data valid exactly two cycles after mem_en.
   initial begin
      rd_t r;
      forever begin
         @(posedge clk);
         #1;
         while (rd_q.size() > 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            r = rd_q.pop_front();
            mem_rdata = r.data;
         end else begin
            mem_rdata = 32'hBAD0_BAD0;
         end
         if (mem_en === 1'b1) begin
            if (mem_we) begin
               mem_model[mem_addr] = mem_wdata;
            end else begin
               r.due  = cyc + 2;
               r.data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : (mem_addr ^ 32'h5A5A_0000);
               rd_q.push_back(r);
            end
         end
      end
   end

   // Scoreboard monitor for the main instance.
   initial begin
      ack_exp_t a;
      cmd_exp_t c;
      forever begin
         @(negedge clk);
         if (if_ack === 1'b1 && d_ack === 1'b1) failNow("ack_overlap");
         if (if_ack === 1'b1 || d_ack === 1'b1) begin
            if (ack_exp_q.size() == 0) begin
               failNow("unexpected_ack");
            end else begin
               a = ack_exp_q.pop_front();
               checkOutput("ack_port_is_data", {31'b0, d_ack}, {31'b0, a.is_data});
               checkOutput("ack_rdata", a.is_data ? d_rdata : if_rdata, a.rdata);
               if (a.cycle >= 0) checkOutput("ack_cycle", cyc, a.cycle);
            end
         end
         if (mem_en === 1'b1) begin
            if (cmd_exp_q.size() == 0) begin
               failNow("unexpected_mem_en");
            end else begin
               c = cmd_exp_q.pop_front();
               checkOutput("mem_we", {31'b0, mem_we}, {31'b0, c.we});
               checkOutput("mem_addr", mem_addr, c.addr);
               if (c.we) checkOutput("mem_wdata", mem_wdata, c.wdata);
               checkOutput("busy_in_issue", {31'b0, busy}, 32'd1);
               if (c.cycle >= 0) checkOutput("mem_en_cycle", cyc, c.cycle);
            end
         end
      end
   end

   // Records command and ack cycles of the MEM_LAT=3 instance.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_en3 === 1'b1) en3_q.push_back(cyc);
         if (d_ack3 === 1'b1 && ack3_cycle < 0) ack3_cycle = cyc;
      end
   end

   // Single request, held until its ack; ack expected at T+5, mem_en at T+1.
   task automatic applyStimulus(input bit is_data, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata);
      int t;
      bit got;
      cmd_exp_t c;
      ack_exp_t a;
      @(negedge clk);
      t = cyc;
      c.we = we; c.addr = addr; c.wdata = wdata; c.cycle = t + 1;
      cmd_exp_q.push_back(c);
      a.is_data = is_data; a.rdata = exp_rdata; a.cycle = t + 5;
      ack_exp_q.push_back(a);
      if (is_data) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if ((is_data && d_ack === 1'b1) || (!is_data && if_ack === 1'b1)) got = 1'b1;
      end
      if (!got) failNow("ack_timeout");
      d_req = 1'b0;
      if_req = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      int t;
      int n;
      cmd_exp_t c;
      ack_exp_t a;

      // Reset held two cycles with both requests high.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("reset_mem_en", {31'b0, mem_en}, 32'd0);
         checkOutput("reset_if_ack", {31'b0, if_ack}, 32'd0);
         checkOutput("reset_d_ack", {31'b0, d_ack}, 32'd0);
         checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      end
      checkOutput("reset_if_rdata", if_rdata, 32'h0);
      checkOutput("reset_d_rdata", d_rdata, 32'h0);
      checkOutput("reset_mem_addr", mem_addr, 32'h0);
      if_req = 1'b0;
      d_req = 1'b0;
      reset = 1'b0;
      mem_model[32'h10] = 32'h8C01_0004;
      repeat (2) @(negedge clk);

      // Fetch, then store (store leaves d_rdata at its reset value).
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 32'h8C01_0004);
      applyStimulus(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0);
      repeat (2) @(negedge clk);

      // Both requests held for ten grants: D,D,D,D,I,D,D,D,D,I.
      for (int k = 0; k < 10; k++) begin
         a.is_data = (k != 4 && k != 9);
         a.rdata   = a.is_data ? 32'h5A5A_0050 : 32'h5A5A_0040;
         a.cycle   = -1;
         ack_exp_q.push_back(a);
         c.we    = 1'b0;
         c.addr  = a.is_data ? 32'h50 : 32'h40;
         c.wdata = 32'h0;
         c.cycle = -1;
         cmd_exp_q.push_back(c);
      end
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
      n = 0;
      for (int i = 0; i < 200 && n < 10; i++) begin
         @(negedge clk);
         if (if_ack === 1'b1 || d_ack === 1'b1) n++;
      end
      if (n < 10) failNow("arb_ack_timeout");
      if_req = 1'b0;
      d_req = 1'b0;
      repeat (3) @(negedge clk);

      // Load abandoned by reset during WAIT.
      @(negedge clk);
      t = cyc;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      c.we = 1'b0; c.addr = 32'h20; c.wdata = 32'h0; c.cycle = t + 1;
      cmd_exp_q.push_back(c);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      d_req = 1'b0;
      @(negedge clk);
      checkOutput("rst_wait_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_wait_d_ack", {31'b0, d_ack}, 32'd0);
      checkOutput("rst_wait_d_rdata", d_rdata, 32'h0);
      checkOutput("rst_wait_if_rdata", if_rdata, 32'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("rst_wait_no_ack_later", {31'b0, d_ack}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF);

      // MEM_LAT=3 instance: held load gives mem_en every 7 cycles.
      @(negedge clk);
      en3_q.delete();
      ack3_cycle = -1;
      t = cyc;
      d_req3 = 1'b1;
      for (int i = 0; i < 60 && en3_q.size() < 3; i++) @(negedge clk);
      d_req3 = 1'b0;
      if (en3_q.size() < 3) begin
         failNow("lat3_grant_timeout");
      end else begin
         checkOutput("lat3_first_mem_en", en3_q[0], t + 1);
         checkOutput("lat3_spacing_1", en3_q[1] - en3_q[0], 32'd7);
         checkOutput("lat3_spacing_2", en3_q[2] - en3_q[1], 32'd7);
         checkOutput("lat3_first_ack", ack3_cycle, t + 6);
      end

      repeat (12) @(negedge clk);
      checkOutput("ack_queue_drained", ack_exp_q.size(), 32'd0);
      checkOutput("cmd_queue_drained", cmd_exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog against a hung run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog_timeout at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
